operand_fetch: RTL and testbench

- Decode-side operand stage directly downstream of the register file. It consumes its two read ports and delivers resolved operands to the execute stage.
- It splits the instruction, drives both read addresses and applies EX/MEM forwarding.
- It detects load-use hazards (stall plus bubble) and holds the ID/EX pipeline register.

---
 rtl/operand_fetch.sv | 155 +++++++++++++++
 tb/tb_operand_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Brief    : Decode-side operand stage. Splits the instruction, drives the
//             register file read addresses, resolves both operands with
//             EX/MEM forwarding, detects load-use hazards and holds the ID/EX
//             pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int WORD_WIDTH  = 32,
  parameter int REG_NUM_LOG = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WORD_WIDTH-1:0]  in_inst,
  input  logic [WORD_WIDTH-1:0]  in_pc,
  input  logic                   flush,
  output logic                   stall_out,
  output logic [REG_NUM_LOG-1:0] rf_readAddr1,
  output logic [REG_NUM_LOG-1:0] rf_readAddr2,
  input  logic [WORD_WIDTH-1:0]  rf_readValue1,
  input  logic [WORD_WIDTH-1:0]  rf_readValue2,
  input  logic                   ex_valid,
  input  logic                   ex_isLoad,
  input  logic                   ex_writeEnable,
  input  logic [REG_NUM_LOG-1:0] ex_writeAddr,
  input  logic [WORD_WIDTH-1:0]  ex_result,
  input  logic                   mem_writeEnable,
  input  logic [REG_NUM_LOG-1:0] mem_writeAddr,
  input  logic [WORD_WIDTH-1:0]  mem_result,
  output logic                   out_valid,
  output logic [WORD_WIDTH-1:0]  out_pc,
  output logic [WORD_WIDTH-1:0]  out_inst,
  output logic [WORD_WIDTH-1:0]  out_op1,
  output logic [WORD_WIDTH-1:0]  out_op2,
  output logic [WORD_WIDTH-1:0]  out_imm,
  output logic [REG_NUM_LOG-1:0] out_writeAddr
);

  // Instruction field positions (MIPS-style encoding)
  localparam int c_RS_LSB  = 21;
  localparam int c_RT_LSB  = 16;
  localparam int c_RD_LSB  = 11;
  localparam int c_OP_LSB  = 26;
  localparam int c_OP_W    = 6;
  localparam int c_IMM_W   = 16;

  localparam logic [REG_NUM_LOG-1:0] c_ZERO_REG = '0;
  localparam logic [c_OP_W-1:0]      c_OP_RTYPE = '0;

  logic [REG_NUM_LOG-1:0] w_rs;
  logic [REG_NUM_LOG-1:0] w_rt;
  logic [REG_NUM_LOG-1:0] w_rd;
  logic [c_OP_W-1:0]      w_opcode;
  logic [WORD_WIDTH-1:0]  w_imm;
  logic [REG_NUM_LOG-1:0] w_dest;
  logic [WORD_WIDTH-1:0]  w_op1;
  logic [WORD_WIDTH-1:0]  w_op2;
  logic                   w_ex_fwd_ok;
  logic                   w_hazard;
  logic                   w_stall;

  logic                   r_valid;
  logic [WORD_WIDTH-1:0]  r_pc;
  logic [WORD_WIDTH-1:0]  r_inst;
  logic [WORD_WIDTH-1:0]  r_op1;
  logic [WORD_WIDTH-1:0]  r_op2;
  logic [WORD_WIDTH-1:0]  r_imm;
  logic [REG_NUM_LOG-1:0] r_writeAddr;

  assign w_rs     = in_inst[c_RS_LSB +: REG_NUM_LOG];
  assign w_rt     = in_inst[c_RT_LSB +: REG_NUM_LOG];
  assign w_rd     = in_inst[c_RD_LSB +: REG_NUM_LOG];
  assign w_opcode = in_inst[c_OP_LSB +: c_OP_W];
  assign w_imm    = {{(WORD_WIDTH-c_IMM_W){in_inst[c_IMM_W-1]}}, in_inst[c_IMM_W-1:0]};
  assign w_dest   = (w_opcode == c_OP_RTYPE) ? w_rd : w_rt;

  assign rf_readAddr1 = w_rs;
  assign rf_readAddr2 = w_rt;

  // A load in EX has no data yet, so it can never be a forwarding source.
  assign w_ex_fwd_ok = ex_valid & ex_writeEnable & ~ex_isLoad;

  // Operand resolution: hard zero, then the youngest producer (EX), then MEM,
  // then the register file. WB needs no path: the file writes on the falling
  // edge, so its value is already on the read ports.
  always_comb begin
    w_op1 = rf_readValue1;
    if (w_rs == c_ZERO_REG)
      w_op1 = '0;
    else if (w_ex_fwd_ok && (ex_writeAddr == w_rs))
      w_op1 = ex_result;
    else if (mem_writeEnable && (mem_writeAddr == w_rs))
      w_op1 = mem_result;
  end

  // Same resolution for the rt operand.
  always_comb begin
    w_op2 = rf_readValue2;
    if (w_rt == c_ZERO_REG)
      w_op2 = '0;
    else if (w_ex_fwd_ok && (ex_writeAddr == w_rt))
      w_op2 = ex_result;
    else if (mem_writeEnable && (mem_writeAddr == w_rt))
      w_op2 = mem_result;
  end

  // Both sources are treated as used regardless of instruction format; this
  // costs an occasional needless bubble but avoids decoding the opcode here.
  assign w_hazard = in_valid & ex_valid & ex_isLoad & ex_writeEnable &
                    (ex_writeAddr != c_ZERO_REG) &
                    ((ex_writeAddr == w_rs) | (ex_writeAddr == w_rt));

  // A flushed instruction is dead, so holding fetch for it would be pointless.
  assign w_stall   = w_hazard & ~flush & ~rst;
  assign stall_out = w_stall;

  // ID/EX pipeline register: reset clears, flush/stall insert a bubble and
  // keep the payload, otherwise capture the resolved instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_inst      <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_writeAddr <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
    end else if (w_stall) begin
      r_valid     <= 1'b0;
    end else begin
      r_valid     <= in_valid;
      r_pc        <= in_pc;
      r_inst      <= in_inst;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_imm       <= w_imm;
      r_writeAddr <= w_dest;
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_inst      = r_inst;
  assign out_op1       = r_op1;
  assign out_op2       = r_op2;
  assign out_imm       = r_imm;
  assign out_writeAddr = r_writeAddr;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch
//  Brief    : Self-checking bench for operand_fetch: directed scenarios plus a
//             randomized run against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        stall_out;
  logic [4:0]  rf_readAddr1;
  logic [4:0]  rf_readAddr2;
  logic [31:0] rf_readValue1;
  logic [31:0] rf_readValue2;
  logic        ex_valid;
  logic        ex_isLoad;
  logic        ex_writeEnable;
  logic [4:0]  ex_writeAddr;
  logic [31:0] ex_result;
  logic        mem_writeEnable;
  logic [4:0]  mem_writeAddr;
  logic [31:0] mem_result;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_imm;
  logic [4:0]  out_writeAddr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the ID/EX register should hold.
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_op1, m_op2, m_imm;
  logic [4:0]  m_wa;

  operand_fetch #(.WORD_WIDTH(32), .REG_NUM_LOG(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .stall_out(stall_out),
    .rf_readAddr1(rf_readAddr1), .rf_readAddr2(rf_readAddr2),
    .rf_readValue1(rf_readValue1), .rf_readValue2(rf_readValue2),
    .ex_valid(ex_valid), .ex_isLoad(ex_isLoad), .ex_writeEnable(ex_writeEnable),
    .ex_writeAddr(ex_writeAddr), .ex_result(ex_result),
    .mem_writeEnable(mem_writeEnable), .mem_writeAddr(mem_writeAddr),
    .mem_result(mem_result),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_writeAddr(out_writeAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Operand value per the forwarding rules, read from the current stimulus.
  function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] rfv);
    if (a == 5'd0) return 32'd0;
    if (ex_valid && ex_writeEnable && !ex_isLoad && ex_writeAddr == a) return ex_result;
    if (mem_writeEnable && mem_writeAddr == a) return mem_result;
    return rfv;
  endfunction

  function automatic logic model_hazard();
    logic [4:0] rs, rt;
    rs = in_inst[25:21];
    rt = in_inst[20:16];
    return in_valid && ex_valid && ex_isLoad && ex_writeEnable && ex_writeAddr != 5'd0 &&
           (ex_writeAddr == rs || ex_writeAddr == rt);
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_inst = 0; in_pc = 0; flush = 0;
    rf_readValue1 = 0; rf_readValue2 = 0;
    ex_valid = 0; ex_isLoad = 0; ex_writeEnable = 0; ex_writeAddr = 0; ex_result = 0;
    mem_writeEnable = 0; mem_writeAddr = 0; mem_result = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    in_valid = 1; in_inst = rtype(5'd9, 5'd2, 5'd3); in_pc = 32'h100;
    ex_valid = 1; ex_isLoad = 1; ex_writeEnable = 1; ex_writeAddr = 5'd9;
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_pc, out_inst, out_op1, out_op2, out_imm, out_writeAddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b pc=%h inst=%h op1=%h op2=%h imm=%h wa=%0d want all 0",
               out_valid, out_pc, out_inst, out_op1, out_op2, out_imm, out_writeAddr);
    end
    rst = 0;
    ex_valid = 0; ex_isLoad = 0; ex_writeEnable = 0;
    in_inst = rtype(5'd1, 5'd2, 5'd3); in_pc = 32'h104;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
      n_fail++; $display("FAIL reset_release: valid=%b pc=%h want 1/00000104", out_valid, out_pc);
    end
  endtask

  task automatic test_regfile();
    idle_inputs();
    in_valid = 1; in_inst = rtype(5'd3, 5'd4, 5'd5); in_pc = 32'h200;
    rf_readValue1 = 32'h11; rf_readValue2 = 32'h22;
    #1;
    n_checks++;
    if (rf_readAddr1 !== 5'd3 || rf_readAddr2 !== 5'd4) begin
      n_fail++; $display("FAIL regfile_addr: a1=%0d a2=%0d want 3/4", rf_readAddr1, rf_readAddr2);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_op1 !== 32'h11 || out_op2 !== 32'h22 || out_writeAddr !== 5'd5 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL regfile_path: op1=%h op2=%h wa=%0d valid=%b want 11/22/5/1",
               out_op1, out_op2, out_writeAddr, out_valid);
    end
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    in_valid = 1; in_inst = rtype(5'd7, 5'd8, 5'd1);
    rf_readValue1 = 32'hDEAD;
    ex_valid = 1; ex_writeEnable = 1; ex_writeAddr = 5'd7; ex_result = 32'hAAAA;
    mem_writeEnable = 1; mem_writeAddr = 5'd7; mem_result = 32'hBBBB;
    @(posedge clk); #1;
    n_checks++;
    if (out_op1 !== 32'hAAAA) begin n_fail++; $display("FAIL fwd_ex_over_mem: got %h want 0000aaaa", out_op1); end
    ex_writeEnable = 0;
    @(posedge clk); #1;
    n_checks++;
    if (out_op1 !== 32'hBBBB) begin n_fail++; $display("FAIL fwd_mem: got %h want 0000bbbb", out_op1); end
    ex_writeEnable = 1; ex_writeAddr = 5'd0; mem_writeAddr = 5'd0;
    in_inst = rtype(5'd0, 5'd8, 5'd1); rf_readValue1 = 32'h5555;
    @(posedge clk); #1;
    n_checks++;
    if (out_op1 !== 32'h0) begin n_fail++; $display("FAIL fwd_r0: got %h want 0", out_op1); end
  endtask

  task automatic test_load_use();
    idle_inputs();
    in_valid = 1; in_inst = rtype(5'd1, 5'd9, 5'd2); in_pc = 32'h300;
    rf_readValue2 = 32'h0BAD;
    ex_valid = 1; ex_isLoad = 1; ex_writeEnable = 1; ex_writeAddr = 5'd9; ex_result = 32'hFFFF;
    #1;
    n_checks++;
    if (stall_out !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall: got %b want 1", stall_out); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble: valid=%b want 0", out_valid); end
    ex_valid = 0; ex_isLoad = 0; ex_writeEnable = 0;
    mem_writeEnable = 1; mem_writeAddr = 5'd9; mem_result = 32'h1234;
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin n_fail++; $display("FAIL loaduse_release: got %b want 0", stall_out); end
    @(posedge clk); #1;
    n_checks++;
    if (out_op2 !== 32'h1234 || out_valid !== 1'b1 || out_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL loaduse_forward: op2=%h valid=%b pc=%h want 1234/1/300", out_op2, out_valid, out_pc);
    end
  endtask

  task automatic test_flush_stall();
    idle_inputs();
    in_valid = 1; in_inst = rtype(5'd1, 5'd9, 5'd2);
    ex_valid = 1; ex_isLoad = 1; ex_writeEnable = 1; ex_writeAddr = 5'd9;
    flush = 1;
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_stall_out: got %b want 0", stall_out); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_immediate();
    idle_inputs();
    in_valid = 1; in_inst = itype(6'h08, 5'd2, 5'd6, 16'h8001);
    @(posedge clk); #1;
    n_checks++;
    if (out_imm !== 32'hFFFF8001 || out_writeAddr !== 5'd6) begin
      n_fail++; $display("FAIL immediate: imm=%h wa=%0d want ffff8001/6", out_imm, out_writeAddr);
    end
    in_inst = itype(6'h08, 5'd2, 5'd6, 16'h7FFE);
    @(posedge clk); #1;
    n_checks++;
    if (out_imm !== 32'h00007FFE) begin
      n_fail++; $display("FAIL immediate_pos: imm=%h want 00007ffe", out_imm);
    end
  endtask

  // Randomized run: addresses drawn from a small pool so forwarding and
  // hazards occur often; occasional reset and flush.
  task automatic test_random(input int n_cycles);
    logic exp_stall;
    logic [4:0] rs, rt, rd;
    for (int i = 0; i <= n_cycles; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if ({out_valid, out_pc, out_inst, out_op1, out_op2, out_imm, out_writeAddr} !==
            {m_valid, m_pc, m_inst, m_op1, m_op2, m_imm, m_wa}) begin
          n_fail++;
          $display("FAIL random_regs[%0d]: got v=%b pc=%h i=%h o1=%h o2=%h im=%h wa=%0d want v=%b pc=%h i=%h o1=%h o2=%h im=%h wa=%0d",
                   i, out_valid, out_pc, out_inst, out_op1, out_op2, out_imm, out_writeAddr,
                   m_valid, m_pc, m_inst, m_op1, m_op2, m_imm, m_wa);
        end
      end
      if (i < n_cycles) begin
        rst             = (i == 0) || ($urandom_range(0, 31) == 0);
        flush           = ($urandom_range(0, 7) == 0);
        in_valid        = ($urandom_range(0, 5) != 0);
        rs              = 5'($urandom_range(0, 3));
        rt              = 5'($urandom_range(0, 3));
        rd              = 5'($urandom_range(0, 31));
        in_inst         = {($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(1, 63)),
                           rs, rt, rd, 11'($urandom)};
        in_pc           = $urandom;
        rf_readValue1   = $urandom;
        rf_readValue2   = $urandom;
        ex_valid        = 1'($urandom_range(0, 1));
        ex_isLoad       = 1'($urandom_range(0, 1));
        ex_writeEnable  = 1'($urandom_range(0, 1));
        ex_writeAddr    = 5'($urandom_range(0, 3));
        ex_result       = $urandom;
        mem_writeEnable = 1'($urandom_range(0, 1));
        mem_writeAddr   = 5'($urandom_range(0, 3));
        mem_result      = $urandom;
        #1;
        exp_stall = model_hazard() && !flush && !rst;
        n_checks++;
        if (stall_out !== exp_stall || rf_readAddr1 !== rs || rf_readAddr2 !== rt) begin
          n_fail++;
          $display("FAIL random_comb[%0d]: stall=%b a1=%0d a2=%0d want %b/%0d/%0d",
                   i, stall_out, rf_readAddr1, rf_readAddr2, exp_stall, rs, rt);
        end
        if (rst) begin
          m_valid = 0; m_pc = 0; m_inst = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_wa = 0;
        end else if (flush || exp_stall) begin
          m_valid = 0;
        end else begin
          m_valid = in_valid;
          m_pc    = in_pc;
          m_inst  = in_inst;
          m_op1   = model_operand(rs, rf_readValue1);
          m_op2   = model_operand(rt, rf_readValue2);
          m_imm   = 32'($signed(in_inst[15:0]));
          m_wa    = (in_inst[31:26] == 6'd0) ? in_inst[15:11] : rt;
        end
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_regfile();
    test_forward_priority();
    test_load_use();
    test_flush_stall();
    test_immediate();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
